// File: rtl/sayeh_pkg.sv
// Shared SAYEH datapath types: window-pointer width/type and window-stack request decode.
package sayeh_pkg;

    localparam int unsigned SAYEH_WP_W = 3;

    typedef logic [SAYEH_WP_W-1:0] wp_t;

    typedef enum logic [1:0] {
        WS_NONE,
        WS_PUSH,
        WS_POP,
        WS_CONFLICT
    } wstack_op_t;

    function automatic wstack_op_t wstack_decode(input logic push, input logic pop);
        wstack_op_t op;
        case ({push, pop})
            2'b10:   op = WS_PUSH;
            2'b01:   op = WS_POP;
            2'b11:   op = WS_CONFLICT;
            default: op = WS_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/wstack_mem.sv
// Window-stack storage: DEPTH x WP_W register array, one write port, one async read port.
module wstack_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WP_W  = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WP_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WP_W-1:0]          rdata
);

    logic [WP_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/window_stack.sv
// Call/return save-restore stack for the SAYEH window pointer.
// Optional macro WSTACK_ERR_EN enables the sticky ovf/unf flags and err_clr.
module window_stack
    import sayeh_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WP_W  = SAYEH_WP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WP_W-1:0]        wp_in,
    input  logic [WP_W-1:0]        offset,
    input  logic                   push,
    input  logic                   pop,
    output logic [WP_W-1:0]        wp_out,
    output logic                   wp_load,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   unf,
    input  logic                   err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [LW-1:0]   sp;
    wstack_op_t      op_c;
    logic            push_ok_c;
    logic            pop_ok_c;
    logic            push_bad_c;
    logic            pop_bad_c;
    logic [WP_W-1:0] rd_data_c;
    logic [AW-1:0]   rd_addr_c;

    // Status is derived only from the registered stack pointer.
    assign full  = (sp == LW'(DEPTH));
    assign empty = (sp == '0);
    assign level = sp;

    assign op_c       = wstack_decode(push, pop);
    assign push_ok_c  = (op_c == WS_PUSH) && !full;
    assign pop_ok_c   = (op_c == WS_POP)  && !empty;
    assign push_bad_c = (op_c == WS_PUSH) && full;
    assign pop_bad_c  = (op_c == WS_POP)  && empty;
    assign rd_addr_c  = AW'(sp - LW'(1));

    wstack_mem #(
        .DEPTH (DEPTH),
        .WP_W  (WP_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_c),
        .waddr (sp[AW-1:0]),
        .wdata (wp_in),
        .raddr (rd_addr_c),
        .rdata (rd_data_c)
    );

    // Stack pointer and pointer-load outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            wp_out  <= '0;
            wp_load <= 1'b0;
        end else begin
            wp_load <= 1'b0;
            if (push_ok_c) begin
                sp      <= sp + LW'(1);
                wp_out  <= WP_W'(wp_in + offset);
                wp_load <= 1'b1;
            end else if (pop_ok_c) begin
                sp      <= sp - LW'(1);
                wp_out  <= rd_data_c;
                wp_load <= 1'b1;
            end
        end
    end

`ifdef WSTACK_ERR_EN
    // Sticky error flags; a new illegal request outranks a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (push_bad_c) begin
                ovf <= 1'b1;
            end else if (err_clr) begin
                ovf <= 1'b0;
            end
            if (pop_bad_c) begin
                unf <= 1'b1;
            end else if (err_clr) begin
                unf <= 1'b0;
            end
        end
    end
`else
    logic unused_err_c;
    assign unused_err_c = err_clr ^ push_bad_c ^ pop_bad_c;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_window_stack.sv
// Self-checking bench for window_stack: directed plan plus random traffic vs. a queue model.
module tb_window_stack;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WP_W  = 3;
`ifdef WSTACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WP_W-1:0] wp_in;
    logic [WP_W-1:0] offset;
    logic            push;
    logic            pop;
    logic            err_clr;
    logic [WP_W-1:0] wp_out;
    logic            wp_load;
    logic            full;
    logic            empty;
    logic [3:0]      level;
    logic            ovf;
    logic            unf;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of saved pointers plus expected outputs.
    int m_stk[$];
    int m_out  = 0;
    int m_load = 0;
    int m_ovf  = 0;
    int m_unf  = 0;

    always #5 clk = ~clk;

    window_stack #(.DEPTH(DEPTH), .WP_W(WP_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wp_in   (wp_in),
        .offset  (offset),
        .push    (push),
        .pop     (pop),
        .wp_out  (wp_out),
        .wp_load (wp_load),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .unf     (unf),
        .err_clr (err_clr)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wp_out"},  int'(wp_out),  m_out);
        check({tag, ".wp_load"}, int'(wp_load), m_load);
        check({tag, ".level"},   int'(level),   m_stk.size());
        check({tag, ".full"},    int'(full),    (m_stk.size() == DEPTH) ? 1 : 0);
        check({tag, ".empty"},   int'(empty),   (m_stk.size() == 0) ? 1 : 0);
        check({tag, ".ovf"},     int'(ovf),     ERR_EN ? m_ovf : 0);
        check({tag, ".unf"},     int'(unf),     ERR_EN ? m_unf : 0);
    endtask

    function automatic void model_reset();
        m_stk.delete();
        m_out  = 0;
        m_load = 0;
        m_ovf  = 0;
        m_unf  = 0;
    endfunction

    function automatic void model_step(input int p, input int q, input int wi, input int off,
                                       input int clr);
        int set_o = 0;
        int set_u = 0;
        m_load = 0;
        if (p == 1 && q == 0) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back(wi);
                m_out  = (wi + off) % (1 << WP_W);
                m_load = 1;
            end else begin
                set_o = 1;
            end
        end else if (q == 1 && p == 0) begin
            if (m_stk.size() > 0) begin
                m_out  = m_stk.pop_back();
                m_load = 1;
            end else begin
                set_u = 1;
            end
        end
        if (set_o == 1) m_ovf = 1; else if (clr == 1) m_ovf = 0;
        if (set_u == 1) m_unf = 1; else if (clr == 1) m_unf = 0;
    endfunction

    // One clock of stimulus, then compare just after the edge.
    task automatic step(input string tag, input int p, input int q, input int wi, input int off,
                        input int clr);
        @(negedge clk);
        push    = p[0];
        pop     = q[0];
        wp_in   = WP_W'(wi);
        offset  = WP_W'(off);
        err_clr = clr[0];
        @(posedge clk);
        #1;
        model_step(p, q, wi, off, clr);
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; wp_in = '0; offset = '0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("idle", 0, 0, 0, 0, 0);
        step("push_3_2", 1, 0, 3, 2, 0);
        check("push_3_2.value", int'(wp_out), 5);
        step("push_5_4_wrap", 1, 0, 5, 4, 0);
        check("wrap.value", int'(wp_out), 1);
        step("strobe_drop", 0, 0, 0, 0, 0);
        step("pop_5", 0, 1, 0, 0, 0);
        check("pop_5.value", int'(wp_out), 5);
        step("pop_3", 0, 1, 0, 0, 0);
        check("pop_3.value", int'(wp_out), 3);
        step("after_pops", 0, 0, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) step("fill", 1, 0, i, 1, 0);
        step("push_full", 1, 0, 7, 7, 0);
        step("ovf_hold", 0, 0, 0, 0, 0);
        step("ovf_clr", 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, 1, 0, 0, 0);
        step("pop_empty", 0, 1, 0, 0, 0);
        step("pop_empty_clr", 0, 1, 0, 0, 1);
        step("unf_clr", 0, 0, 0, 0, 1);

        step("pre_conf_a", 1, 0, 6, 1, 0);
        step("pre_conf_b", 1, 0, 2, 3, 0);
        step("push_pop_conflict", 1, 1, 4, 4, 0);
        step("pop_after_push_a", 1, 0, 1, 1, 0);
        step("pop_after_push_b", 0, 1, 0, 0, 0);
        step("to_four_a", 1, 0, 3, 0, 0);
        step("to_four_b", 1, 0, 7, 0, 0);
        check("level4", int'(level), 4);

        // Asynchronous reset between edges.
        @(negedge clk);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_push", 1, 0, 6, 0, 0);
        step("post_reset_pop", 0, 1, 0, 0, 0);
        check("entry0.value", int'(wp_out), 6);

        // Random traffic biased towards both boundaries.
        for (int i = 0; i < 400; i++) begin
            int r;
            int p;
            int q;
            r = int'($urandom_range(0, 99));
            p = (r < ((i / 100) % 2 == 0 ? 60 : 30)) ? 1 : 0;
            q = (int'($urandom_range(0, 99)) < 40) ? 1 : 0;
            step("random", p, q, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 (int'($urandom_range(0, 9)) == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/window_stack.md
# window_stack

Call/return save-restore stack for the SAYEH register-window pointer. On a push it saves the current window pointer and produces the advanced pointer. On a pop it restores the most recently saved pointer. It sits beside the window-pointer register in the datapath: it receives the live pointer and a call offset from the controller, and drives a one-cycle load request plus the value to load back into the pointer register.

## Interface
- DEPTH, 8, number of saved window pointers (power of two, 2..16)
- WP_W, 3, window-pointer width in bits
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wp_in  in  WP_W  current window-pointer value
- offset  in  WP_W  window advance applied on push
- push  in  1  save wp_in and advance (call)
- pop  in  1  restore last saved pointer (return)
- wp_out  out  WP_W  pointer value to load into the window-pointer register
- wp_load  out  1  one-cycle strobe; wp_out valid when high
- full  out  1  DEPTH entries held
- empty  out  1  zero entries held
- level  out  $clog2(DEPTH)+1  entries held
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty
- err_clr  in  1  clears ovf/unf

## Operation
- Storage: DEPTH x WP_W array with stack pointer sp (0..DEPTH).
  - full = (sp==DEPTH); empty = (sp==0); level = sp.
- Legal push (push=1, pop=0, !full):
  - mem[sp] <= wp_in; sp <= sp+1.
  - wp_out <= (wp_in + offset) mod 2^WP_W; wrap-around is silent.
  - wp_load <= 1.
- Legal pop (pop=1, push=0, !empty):
  - sp <= sp-1; wp_out <= mem[sp-1]; wp_load <= 1.
- Push while full: rejected; sp, mem and wp_out unchanged; wp_load stays 0; ovf <= 1.
- Pop while empty: rejected; nothing changes; unf <= 1.
- push and pop in the same cycle: no-op, no strobe, no error flag.
- err_clr: clears ovf/unf. When it coincides with a new illegal request, the set wins.
- Reset (async, any time, including mid-sequence):
  - sp=0; wp_out=0; wp_load=0; ovf=0; unf=0.
  - Array contents are don't-care.
  - full=0; empty=1; level=0.

## Timing
- Single-cycle latency: a request sampled at edge N gives wp_out/wp_load valid after edge N.
- wp_load is high for exactly one cycle per accepted request.
- Back-to-back requests are accepted every cycle.
- A pop in the cycle after a push returns the value just pushed.
- full, empty and level reflect sp after the edge. They are registered-derived, with no combinational path from push/pop.
- wp_in and offset are sampled only on a push edge.

## Configuration
- WSTACK_ERR_EN defined: ovf, unf and err_clr behave as above.
- WSTACK_ERR_EN undefined:
  - ovf and unf are tied 0; err_clr is ignored.
  - Illegal requests are still rejected silently, with identical sp/wp_out behaviour.

## Structure
- Shared package sayeh_pkg holds:
  - WP_W default constant.
  - Typedef wp_t (logic [WP_W-1:0]).
  - Enum wstack_op_t {WS_NONE, WS_PUSH, WS_POP, WS_CONFLICT} for request decode.
- Sub-module wstack_mem: DEPTH x WP_W register array with one write port and one asynchronous read port at sp-1. The top level holds the sp counter, decode, output registers and error flags.

## Test plan
- Reset, then idle: wp_out=0, wp_load=0, empty=1, full=0, level=0, ovf=unf=0.
- Push with wp_in=3, offset=2, then push with wp_in=5, offset=4:
  - First push: wp_out=5 with strobe.
  - Second push: wp_out=1 (wrap) with strobe; level=2.
  - Two pops then return 5 and then 3, each with a one-cycle strobe; empty=1 afterwards.
- Fill with 8 pushes: full=1. A 9th push gives no strobe, level stays 8, ovf=1. err_clr clears ovf.
- Pop on empty: no strobe, unf=1. Pop with err_clr in the same cycle: unf stays 1.
- push and pop together with level=2: no strobe, level stays 2, no error flag.
- Assert rst_n low between clock edges with level=4: outputs go to reset values immediately, with no clock edge needed. The next push stores at entry 0.
